phy_tx_serializer: RTL
======================

# phy_tx_serializer

Transmit serializer of the USB 1.1 full-speed PHY, directly upstream of the NRZI encoder/bit-stuffer stage. It accepts packet bytes over a valid/ready handshake and prepends SYNC. It shifts the packet LSB-first as one bit per bit-time strobe, holding the current bit whenever the NRZI stage requests a stuff slot, and appends the EOP (SE0, SE0, J). It produces the bit stream, bit strobe, NRZI-enable and SE0-enable that the NRZI stage consumes.

## Interface
- CLK_DIV, 4, clk cycles per bit time (48 MHz clk → 12 Mb/s); ≥2
- clk  in  1  single clock
- rst  in  1  reset; synchronous, active-high
- tx_valid  in  1  packet data available; held high for whole packet, low after last byte
- tx_data  in  8  current byte, stable while tx_valid
- tx_ready  out  1  one-cycle pulse: tx_data captured this cycle
- tx_active  out  1  high from SYNC start through last EOP J bit
- tx_dat  out  1  serial bit to NRZI stage
- tx_dat_en  out  1  one-cycle bit strobe, every CLK_DIV cycles while active
- tx_nrzi_stop  in  1  NRZI stage has seen six ones; the next strobe is a stuff slot
- tx_nrzi_en  out  1  NRZI encoding enabled (SYNC/DATA, pending stuff)
- tx_se_en  out  1  drive SE0

## Operation
- States: IDLE, SYNC, DATA, EOP_SE0, EOP_J. Registers: div_cnt, bit_cnt[2:0], shift[7:0], eop_cnt.
- IDLE, tx_valid=1 → SYNC; shift←8'h80, bit_cnt←0, div_cnt←0.
- Strobe: tx_dat_en = active && div_cnt==CLK_DIV-1; div_cnt wraps to 0.
- Consuming strobe: tx_dat_en && !tx_nrzi_stop. Only consuming strobes advance bit_cnt, shift or eop_cnt. A stalled strobe leaves all state unchanged; the NRZI stage inserts the stuffed bit.
- tx_dat = shift[0] in SYNC/DATA; 0 in EOP_SE0; 1 in EOP_J/IDLE.
- On the consuming strobe of bit 7 (SYNC or DATA):
  - tx_valid=1 → shift←tx_data, tx_ready=1 that cycle, state DATA.
  - tx_valid=0 → EOP_SE0, eop_cnt←0. A zero-byte packet is legal.
- EOP_SE0 lasts 2 consuming strobes, then EOP_J.
- EOP_J lasts 1 consuming strobe, then IDLE; tx_active drops the next cycle.
- tx_nrzi_en = SYNC || DATA || (EOP_SE0 && eop_cnt==0 && tx_nrzi_stop). The last term lets a stuff after trailing ones complete before SE0.
- tx_se_en = EOP_SE0 && !(eop_cnt==0 && tx_nrzi_stop).
- tx_valid falling mid-byte is ignored until the byte boundary.

## Timing
- Reset values: state IDLE, tx_ready 0, tx_active 0, tx_dat 1, tx_dat_en 0, tx_nrzi_en 0, tx_se_en 0.
- tx_valid sampled high at edge t: tx_active=1 from t+1; first tx_dat_en during cycle t+CLK_DIV.
- Packet length, N bytes and S stuffs: 8+8N+3+S strobes.
- tx_ready coincides with the consuming strobe of the previous byte's bit 7. Upstream must present the next byte before then.
- tx_nrzi_stop is used only on the strobe cycle. It is registered in the NRZI stage and clears after the stuff strobe.
- rst mid-packet: the next cycle shows all reset values. No EOP is emitted; the NRZI stage resets concurrently.
- tx_valid re-asserted in EOP_J: the new packet starts only after IDLE is reached (≥1 idle cycle).

## Structure
- Shared package phy_tx_pkg: state enum, SYNC_PATTERN=8'h80, EOP_SE0_BITS=2, EOP_J_BITS=1.
- One sub-module: phy_tx_bit_strobe. It holds div_cnt and generates the strobe, with enable/clear inputs and the CLK_DIV parameter.

## Test plan
- Reset: hold rst 3 cycles mid-DATA → all outputs at reset values next cycle; no further strobes.
- One byte 0x00, no stuff:
  - 19 strobes; tx_dat = 0000000100000000 then SE0, SE0, J.
  - tx_ready pulses once, on strobe 8.
- One byte 0xFF: stall after data bit 4 (ones run 1+5). 20 strobes total; bit held across the stall; tx_dat_en period always CLK_DIV.
- One byte 0xFC (trailing six ones): first EOP strobe has tx_nrzi_en=1, tx_se_en=0. The next two strobes have tx_se_en=1. 20 strobes total.
- Three bytes 0xA5, 0x3C, 0x81 back-to-back:
  - tx_ready pulses on strobes 8, 16, 24.
  - LSB-first order verified.
  - tx_active high for 35 strobes' span.
- Zero-byte packet (tx_valid drops before strobe 8): 11 strobes, no tx_ready.

Source files
------------

// File: rtl/phy_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit serializer.
package phy_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_DATA    = 3'd2,
    ST_EOP_SE0 = 3'd3,
    ST_EOP_J   = 3'd4
  } tx_state_e;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int         EOP_SE0_BITS = 2;
  localparam int         EOP_J_BITS   = 1;
  localparam int         EOP_CNT_W    = 2;

  function automatic logic is_shifting(input tx_state_e s);
    return (s == ST_SYNC) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/phy_tx_bit_strobe.sv
// Bit-time divider: one-cycle strobe every CLK_DIV enabled cycles.
module phy_tx_bit_strobe #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic strobe
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] div_cnt;

  // Divider keeps running through stalled strobes so the bit period never stretches.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (clr) begin
      div_cnt <= '0;
    end else if (en) begin
      if (div_cnt == LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + ONE;
      end
    end else begin
      div_cnt <= div_cnt;
    end
  end

  assign strobe = en && (div_cnt == LAST);

endmodule

// File: rtl/phy_tx_serializer.sv
// USB 1.1 FS transmit serializer: SYNC, LSB-first packet bits, EOP, with
// stuff-slot stalls requested by the downstream NRZI/bit-stuff stage.
module phy_tx_serializer
  import phy_tx_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       tx_dat,
  output logic       tx_dat_en,
  input  logic       tx_nrzi_stop,
  output logic       tx_nrzi_en,
  output logic       tx_se_en
);

  localparam logic [EOP_CNT_W-1:0] SE0_LAST = EOP_CNT_W'(EOP_SE0_BITS - 1);
  localparam logic [EOP_CNT_W-1:0] J_LAST   = EOP_CNT_W'(EOP_J_BITS - 1);
  localparam logic [EOP_CNT_W-1:0] EOP_ONE  = EOP_CNT_W'(1);

  tx_state_e            state, state_nxt;
  logic [7:0]           shift, shift_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [EOP_CNT_W-1:0] eop_cnt, eop_cnt_nxt;
  logic                 active, strobe, consume, eop_stuff_pending;

  assign active  = (state != ST_IDLE);
  assign consume = strobe && !tx_nrzi_stop;

  phy_tx_bit_strobe #(.CLK_DIV(CLK_DIV)) u_bit_strobe (
    .clk    (clk),
    .rst    (rst),
    .en     (active),
    .clr    (!active),
    .strobe (strobe)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= 8'h00;
      bit_cnt <= 3'd0;
      eop_cnt <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      eop_cnt <= eop_cnt_nxt;
    end
  end

  // Next-state logic; only consuming strobes move the packet forward.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    eop_cnt_nxt = eop_cnt;
    tx_ready    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tx_valid) begin
          state_nxt   = ST_SYNC;
          shift_nxt   = SYNC_PATTERN;
          bit_cnt_nxt = 3'd0;
          eop_cnt_nxt = '0;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (consume) begin
          if (bit_cnt == 3'd7) begin
            if (tx_valid) begin
              shift_nxt   = tx_data;
              tx_ready    = 1'b1;
              bit_cnt_nxt = 3'd0;
              state_nxt   = ST_DATA;
            end else begin
              eop_cnt_nxt = '0;
              state_nxt   = ST_EOP_SE0;
            end
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end else begin
          state_nxt = state;
        end
      end
      ST_EOP_SE0: begin
        if (consume) begin
          if (eop_cnt == SE0_LAST) begin
            eop_cnt_nxt = '0;
            state_nxt   = ST_EOP_J;
          end else begin
            eop_cnt_nxt = eop_cnt + EOP_ONE;
          end
        end else begin
          state_nxt = state;
        end
      end
      ST_EOP_J: begin
        if (consume) begin
          if (eop_cnt == J_LAST) begin
            eop_cnt_nxt = '0;
            state_nxt   = ST_IDLE;
          end else begin
            eop_cnt_nxt = eop_cnt + EOP_ONE;
          end
        end else begin
          state_nxt = state;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // A stuff requested after trailing ones must be NRZI-encoded before SE0 starts.
  assign eop_stuff_pending = (state == ST_EOP_SE0) && (eop_cnt == '0) && tx_nrzi_stop;

  // Line-level outputs decoded from the current state.
  always_comb begin
    tx_dat = 1'b1;
    case (state)
      ST_SYNC, ST_DATA: tx_dat = shift[0];
      ST_EOP_SE0:       tx_dat = 1'b0;
      default:          tx_dat = 1'b1;
    endcase
  end

  assign tx_active  = active;
  assign tx_dat_en  = strobe;
  assign tx_nrzi_en = is_shifting(state) || eop_stuff_pending;
  assign tx_se_en   = (state == ST_EOP_SE0) && !((eop_cnt == '0) && tx_nrzi_stop);

endmodule
